// File: rtl/registers.sv
// registers: the TD4 4-bit CPU register file and datapath.
// It holds general registers A and B, the output register C, the program
// counter D and a carry flag. A source mux and a 4-bit adder feed all of them.
//
// Ports
//   clk       in   system clock; all state updates on the rising edge
//   clr       in   synchronous active-high reset
//   load_n    in   [3:0] active-low load enables {D, C, B, A}
//   select    in   [1:0] adder source: 00=A 01=B 10=in 11=zero
//   in        in   [3:0] input-port data
//   immed     in   [3:0] immediate operand
//   out       out  [3:0] register C
//   addr_rom  out  [3:0] register D (PC)
//   carry_n   out  inverted carry flag

// One 4-bit register with a clear and an active-low load. It holds its
// value when not loaded.
module registers_lane (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_ff @(posedge clk) begin
    if (clr)        q <= '0;
    else if (!ld_n) q <= d;
  end
endmodule

module registers (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] load_n,
  input  logic [1:0] select,
  input  logic [3:0] in,
  input  logic [3:0] immed,
  output logic [3:0] out,
  output logic [3:0] addr_rom,
  output logic       carry_n
);
  localparam int NUM_GP = 3;   // A, B, C share identical load/hold behaviour

  logic [NUM_GP-1:0][3:0] gp;  // [0]=A [1]=B [2]=C
  logic [3:0]             pc;
  logic                   flag;
  logic [3:0]             src;
  logic [4:0]             add;
  logic [3:0]             sum;
  logic                   cout;

  // Source mux. The zero source turns the adder into a load-immediate.
  always_comb begin
    src = '0;
    unique case (select)
      2'b00: src = gp[0];
      2'b01: src = gp[1];
      2'b10: src = in;
      2'b11: src = '0;
    endcase
  end

  // Widen both operands so the carry-out lands in bit 4.
  assign add  = {1'b0, src} + {1'b0, immed};
  assign sum  = add[3:0];
  assign cout = add[4];

  genvar g;
  generate
    for (g = 0; g < NUM_GP; g++) begin : g_gp
      registers_lane u_lane (
        .clk  (clk),
        .clr  (clr),
        .ld_n (load_n[g]),
        .d    (sum),
        .q    (gp[g])
      );
    end
  endgenerate

  // The PC either jumps to sum or advances. It wraps naturally at 4 bits.
  always_ff @(posedge clk) begin
    if (clr)             pc <= '0;
    else if (!load_n[3]) pc <= sum;
    else                 pc <= pc + 4'd1;
  end

  // The carry flag is rewritten every cycle, even when nothing is loaded.
  always_ff @(posedge clk) begin
    if (clr) flag <= 1'b0;
    else     flag <= cout;
  end

  assign out      = gp[2];
  assign addr_rom = pc;
  assign carry_n  = ~flag;
endmodule

// File: tb/tb_registers.sv
module tb_registers;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] load_n = 4'hF;
  logic [1:0] select = 2'b00;
  logic [3:0] in = 4'h0;
  logic [3:0] immed = 4'h0;
  logic [3:0] out;
  logic [3:0] addr_rom;
  logic       carry_n;

  registers dut (
    .clk(clk), .clr(clr), .load_n(load_n), .select(select), .in(in),
    .immed(immed), .out(out), .addr_rom(addr_rom), .carry_n(carry_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    out;
    int    addr;
    int    carry_n;
    string tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: the CPU's architectural registers held as plain ints.
  int ra = 0, rb = 0, rc = 0, rd = 0, cf = 0;

  // Apply one cycle of controls, advance the model and queue the expected outputs.
  task automatic step(input bit c, input logic [3:0] ln, input logic [1:0] sel,
                      input logic [3:0] i, input logic [3:0] im, input string tag);
    int s, t, sm;
    exp_t e;
    @(negedge clk);
    clr = c; load_n = ln; select = sel; in = i; immed = im;
    case (sel)
      2'd0: s = ra;
      2'd1: s = rb;
      2'd2: s = int'(i);
      default: s = 0;
    endcase
    t  = s + int'(im);
    sm = t % 16;
    if (c) begin
      ra = 0; rb = 0; rc = 0; rd = 0; cf = 0;
    end else begin
      if (!ln[0]) ra = sm;
      if (!ln[1]) rb = sm;
      if (!ln[2]) rc = sm;
      rd = (!ln[3]) ? sm : (rd + 1) % 16;
      cf = (t > 15) ? 1 : 0;
    end
    e.out = rc; e.addr = rd; e.carry_n = 1 - cf; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp({e.tag, ".out"},      int'(out),      e.out);
        cmp({e.tag, ".addr_rom"}, int'(addr_rom), e.addr);
        cmp({e.tag, ".carry_n"},  int'(carry_n),  e.carry_n);
      end
    end
  end

  initial begin
    int wait_cycles;
    step(1, 4'hF, 2'd0, 4'h0, 4'h0, "reset0");
    step(1, 4'hF, 2'd0, 4'h0, 4'h0, "reset1");
    for (int k = 0; k < 20; k++) step(0, 4'hF, 2'd0, 4'h0, 4'h0, "count");

    step(0, 4'b1110, 2'd2, 4'b0101, 4'h0, "load_a");
    step(0, 4'b1011, 2'd0, 4'h0,    4'h0, "xfer_a_c");

    step(0, 4'b1101, 2'd2, 4'b1010, 4'h0, "load_b");
    step(0, 4'b0111, 2'd1, 4'h0,    4'h0, "jump");
    step(0, 4'hF,    2'd0, 4'h0,    4'h0, "after_jump1");
    step(0, 4'hF,    2'd0, 4'h0,    4'h0, "after_jump2");

    step(0, 4'b1011, 2'd1, 4'h0, 4'b0110, "carry_set");
    step(0, 4'hF,    2'd0, 4'h0, 4'h0,    "carry_clr");

    step(0, 4'b1100, 2'd3, 4'h0, 4'b1001, "ld_imm_ab");
    step(0, 4'b1011, 2'd0, 4'h0, 4'h0,    "xfer_a");
    step(0, 4'b1011, 2'd1, 4'h0, 4'h0,    "xfer_b");

    step(0, 4'b1011, 2'd3, 4'h0, 4'h7, "pre_rst");
    step(1, 4'b0110, 2'd2, 4'hF, 4'hF, "mid_reset");

    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 19) == 0), 4'($urandom), 2'($urandom),
           4'($urandom), 4'($urandom), "random");
    end

    // Drain the scoreboard, with a bound.
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
